execute_pipe_stage: RTL and testbench

//  Execute (E) stage for the pipelined Y86-64 core, parametrised in datapath width.

---
 rtl/y86_pkg.sv | 44 ++++
 rtl/cond_eval.sv | 32 +++
 rtl/execute_pipe_stage.sv | 131 +++++++++++++
 tb/tb_execute_pipe_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction/function codes, status codes,
// condition-code bit positions and ALU function codes.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] S_BUB = 3'd0;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

endpackage

// File: rtl/cond_eval.sv
// Branch / conditional-move condition evaluation against {ZF,SF,OF}.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       illegal
);

  logic zf, sf, of_f, lt;

  always_comb begin
    zf      = cc[CC_ZF];
    sf      = cc[CC_SF];
    of_f    = cc[CC_OF];
    lt      = sf ^ of_f;
    cnd     = 1'b0;
    illegal = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_pipe_stage.sv
// Y86-64 execute stage: ALU, condition codes, cmov cancel and the M pipeline register.
module execute_pipe_stage
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned STAT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAT_W-1:0] E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [WIDTH-1:0]  E_valA,
  input  logic [WIDTH-1:0]  E_valB,
  input  logic [WIDTH-1:0]  E_valC,
  input  logic [REG_W-1:0]  E_dstE,
  input  logic [REG_W-1:0]  E_dstM,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [WIDTH-1:0]  e_valE,
  output logic [REG_W-1:0]  e_dstE,
  output logic              e_cnd,
  output logic [STAT_W-1:0] M_stat,
  output logic [3:0]        M_icode,
  output logic              M_cnd,
  output logic [WIDTH-1:0]  M_valE,
  output logic [WIDTH-1:0]  M_valA,
  output logic [REG_W-1:0]  M_dstE,
  output logic [REG_W-1:0]  M_dstM,
  output logic [2:0]        cc_out
);

  localparam logic [REG_W-1:0] RNONE_W  = {REG_W{1'b1}};
  localparam logic [2:0]       CC_RESET = 3'b100;

  logic              is_opq, is_cond, opq_illegal, ce_cnd, ce_illegal, illegal;
  logic              set_cc, sa, sb, sr, of_f;
  logic [3:0]        alu_fun;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_res;
  logic [2:0]        new_cc;
  logic [STAT_W-1:0] e_stat;

  cond_eval u_cond_eval (
    .cc      (cc_out),
    .ifun    (E_ifun),
    .cnd     (ce_cnd),
    .illegal (ce_illegal)
  );

  // Exceptional status downstream blocks the CC write.
  function automatic logic stat_blocks(input logic [STAT_W-1:0] s);
    return (s == STAT_W'(S_ADR)) || (s == STAT_W'(S_HLT)) || (s == STAT_W'(S_INS));
  endfunction

  // Operand selection, ALU and flag generation.
  always_comb begin
    is_opq      = (E_icode == I_OPQ);
    is_cond     = (E_icode == I_JXX) || (E_icode == I_CMOVXX);
    opq_illegal = is_opq && (E_ifun > F_XOR);
    illegal     = opq_illegal || (is_cond && ce_illegal);

    alu_a = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:              alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:              alu_a = '0 - WIDTH'(8);
      I_RET, I_POPQ:                alu_a = WIDTH'(8);
      default:                      alu_a = '0;
    endcase
    alu_b   = ((E_icode == I_RRMOVQ) || (E_icode == I_IRMOVQ)) ? '0 : E_valB;
    alu_fun = is_opq ? E_ifun : F_ADD;

    alu_res = '0;
    case (alu_fun)
      F_ADD:   alu_res = alu_b + alu_a;
      F_SUB:   alu_res = alu_b - alu_a;
      F_AND:   alu_res = alu_b & alu_a;
      F_XOR:   alu_res = alu_b ^ alu_a;
      default: alu_res = '0;
    endcase

    sa   = alu_a[WIDTH-1];
    sb   = alu_b[WIDTH-1];
    sr   = alu_res[WIDTH-1];
    of_f = 1'b0;
    if (alu_fun == F_ADD)      of_f = (sa == sb) && (sr != sa);
    else if (alu_fun == F_SUB) of_f = (sa != sb) && (sr != sb);

    new_cc        = 3'b000;
    new_cc[CC_ZF] = (alu_res == '0);
    new_cc[CC_SF] = sr;
    new_cc[CC_OF] = of_f;

    set_cc = is_opq && !opq_illegal && !stat_blocks(m_stat) && !stat_blocks(W_stat);
    e_cnd  = is_cond && !ce_illegal && ce_cnd;
    e_valE = illegal ? '0 : alu_res;
    e_dstE = ((E_icode == I_CMOVXX) && !e_cnd) ? RNONE_W : E_dstE;
    e_stat = illegal ? STAT_W'(S_INS) : E_stat;
  end

  // Condition-code register: reset wins, stall freezes, bubble has no effect.
  always_ff @(posedge clk) begin
    if (!rst_n)                 cc_out <= CC_RESET;
    else if (set_cc && !M_stall) cc_out <= new_cc;
  end

  // M pipeline register; a bubble loads the same NOP image as reset.
  always_ff @(posedge clk) begin
    if (!rst_n || M_bubble) begin
      M_stat  <= STAT_W'(S_BUB);
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE_W;
      M_dstM  <= RNONE_W;
    end else if (!M_stall) begin
      M_stat  <= e_stat;
      M_icode <= E_icode;
      M_cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_pipe_stage.sv
// Directed-vector bench for execute_pipe_stage with hand-computed expectations.
module tb_execute_pipe_stage;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned STAT_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [STAT_W-1:0] E_stat, m_stat, W_stat;
  logic [3:0]        E_icode, E_ifun;
  logic [WIDTH-1:0]  E_valA, E_valB, E_valC;
  logic [REG_W-1:0]  E_dstE, E_dstM;
  logic              M_stall, M_bubble;
  logic [WIDTH-1:0]  e_valE, M_valE, M_valA;
  logic [REG_W-1:0]  e_dstE, M_dstE, M_dstM;
  logic              e_cnd, M_cnd;
  logic [STAT_W-1:0] M_stat;
  logic [3:0]        M_icode;
  logic [2:0]        cc_out;

  int nvec = 0;
  int nmis = 0;

  execute_pipe_stage #(.WIDTH(WIDTH), .REG_W(REG_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .M_stat(M_stat), .M_icode(M_icode),
    .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc_out(cc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] vc, input logic [3:0] dste);
    E_icode = icode;
    E_ifun  = ifun;
    E_valA  = va;
    E_valB  = vb;
    E_valC  = vc;
    E_dstE  = dste;
    E_dstM  = 4'hF;
    E_stat  = 3'd1;
  endtask

  initial begin
    rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
    m_stat = 3'd1; W_stat = 3'd1;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    tick();
    check("rst_icode", 64'(M_icode), 64'd1);
    check("rst_stat",  64'(M_stat),  64'd0);
    check("rst_cnd",   64'(M_cnd),   64'd0);
    check("rst_valE",  M_valE,       64'd0);
    check("rst_valA",  M_valA,       64'd0);
    check("rst_dstE",  64'(M_dstE),  64'hF);
    check("rst_dstM",  64'(M_dstM),  64'hF);
    check("rst_cc",    64'(cc_out),  64'h4);
    rst_n = 1'b1;

    // ADD overflow into the sign bit
    drive(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2);
    #1 check("add_e_valE", e_valE, 64'h8000_0000_0000_0000);
    tick();
    check("add_M_valE",  M_valE,      64'h8000_0000_0000_0000);
    check("add_M_icode", 64'(M_icode), 64'h6);
    check("add_M_dstE",  64'(M_dstE),  64'h2);
    check("add_cc",      64'(cc_out),  64'h3);

    // SUB to zero, then JXX e
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2);
    tick();
    check("sub0_cc", 64'(cc_out), 64'h4);
    drive(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 4'hF);
    #1 check("jxx_e_cnd", 64'(e_cnd), 64'd1);
    tick();
    check("jxx_M_cnd", 64'(M_cnd), 64'd1);

    // CMOVL with cc=100 is not taken
    drive(4'h2, 4'h2, 64'h11, 64'h99, 64'd0, 4'h3);
    #1 check("cmovl_e_cnd",  64'(e_cnd),  64'd0);
    check("cmovl_e_dstE", 64'(e_dstE), 64'hF);
    tick();
    check("cmovl_M_dstE", 64'(M_dstE), 64'hF);
    check("cmovl_M_valE", M_valE,      64'h11);

    // Exception in memory stage blocks the CC write
    m_stat = 3'd3;
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
    tick();
    check("sadr_M_valE", M_valE,      64'd2);
    check("sadr_cc",     64'(cc_out), 64'h4);
    m_stat = 3'd1;

    // Stalled OPQ: CC and M frozen
    M_stall = 1'b1;
    drive(4'h6, 4'h3, 64'd1, 64'd2, 64'd0, 4'h5);
    tick();
    check("stall_opq_cc",   64'(cc_out), 64'h4);
    check("stall_opq_valE", M_valE,      64'd2);

    // PUSHQ held by a two-cycle stall, then released
    drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("push_stall_valE",  M_valE,       64'd2);
      check("push_stall_icode", 64'(M_icode), 64'h6);
    end
    M_stall = 1'b0;
    tick();
    check("push_M_valE",  M_valE,       64'hF8);
    check("push_M_icode", 64'(M_icode), 64'hA);

    // SUB overflow: 0x8000..0 - 1
    drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h2);
    tick();
    check("subof_M_valE", M_valE,      64'h7FFF_FFFF_FFFF_FFFF);
    check("subof_cc",     64'(cc_out), 64'h1);

    // AND clears all flags
    drive(4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 4'h2);
    tick();
    check("and_M_valE", M_valE,      64'h30);
    check("and_cc",     64'(cc_out), 64'h0);

    // CMOVG with cc=000 is taken
    drive(4'h2, 4'h6, 64'h22, 64'd0, 64'd0, 4'h3);
    #1 check("cmovg_e_cnd",  64'(e_cnd),  64'd1);
    check("cmovg_e_dstE", 64'(e_dstE), 64'h3);

    // Illegal OPQ ifun
    drive(4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 4'h2);
    #1 check("ill_e_valE", e_valE, 64'd0);
    tick();
    check("ill_M_stat", 64'(M_stat), 64'h4);
    check("ill_cc",     64'(cc_out), 64'h0);

    // Illegal JXX ifun
    drive(4'h7, 4'h9, 64'd0, 64'd0, 64'd0, 4'hF);
    #1 check("illj_e_cnd", 64'(e_cnd), 64'd0);
    tick();
    check("illj_M_stat", 64'(M_stat), 64'h4);

    // Bubble beats stall
    M_bubble = 1'b1; M_stall = 1'b1;
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'd5, 4'h4);
    tick();
    check("bub_M_icode", 64'(M_icode), 64'h1);
    check("bub_M_dstE",  64'(M_dstE),  64'hF);
    check("bub_M_stat",  64'(M_stat),  64'h0);
    M_bubble = 1'b0; M_stall = 1'b0;

    // Reset mid-stream discards in-flight state
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h55, 4'h4);
    tick();
    check("irmov_M_valE", M_valE, 64'h55);
    drive(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2);
    rst_n = 1'b0;
    tick();
    check("mrst_icode", 64'(M_icode), 64'h1);
    check("mrst_valE",  M_valE,       64'd0);
    check("mrst_dstE",  64'(M_dstE),  64'hF);
    check("mrst_cc",    64'(cc_out),  64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
